rr_index_arbiter: RTL and testbench
===================================

# rr_index_arbiter

Round-robin arbiter that picks one of `2**n` requesters and presents the winner as a binary index plus an enable. It sits directly upstream of `decoder_generic`: `w` and `en` connect straight to the decoder's `w` and `en`, which turns them into the one-hot grant vector. The block holds each grant until the requester signals completion or a hold timeout expires. It then advances the priority pointer so every requester gets fair service.

## Interface
- `n`, 3, index width; number of requesters is `2**n`
- `max_hold`, 16, maximum cycles a grant stays asserted without `done`; 0 disables the timeout
- `clk` input 1: single clock, rising-edge
- `rst_n` input 1: asynchronous active-low reset
- `req` input `2**n`: request vector; bit i is requester i
- `done` input 1: current grant holder releases the grant
- `w` output `n`: granted index, registered; feeds `decoder_generic.w`
- `en` output 1: grant valid, registered; feeds `decoder_generic.en`
- `tout` output 1: one-cycle pulse when a grant is revoked by timeout

## Operation
- Internal state: FSM {IDLE, GRANT}; priority pointer `ptr` [n-1:0]; hold counter `cnt`, wide enough for `max_hold`.
- Reset (async, `rst_n`=0): state=IDLE, `w`=0, `en`=0, `tout`=0, `ptr`=0, `cnt`=0. Outputs drop immediately, mid-grant included.
- IDLE, `req`=0: stay in IDLE, `en`=0, `w` holds its last value.
- IDLE, `req`≠0: pick the first set bit scanning `ptr`, `ptr+1`, … with modulo `2**n` wrap.
  - `w` ← winner, `en` ← 1, `cnt` ← 0, state → GRANT.
- GRANT, `done`=1: `en` ← 0, `ptr` ← `w+1` mod `2**n` (7→0 for n=3), state → IDLE.
- GRANT, `done`=0, `max_hold`≠0, `cnt`==`max_hold-1`: same as `done` (`en` ← 0, pointer advances, state → IDLE), and additionally `tout` ← 1 for one cycle.
- GRANT otherwise: `cnt` ← `cnt+1`; `w` and `en` held.
- The grant is held even if `req[w]` deasserts. Only `done` or the timeout ends it.
- `done` in IDLE is ignored.
- `done` and the timeout on the same edge: treated as `done`, so `tout`=0.
- Requests arriving during GRANT are not arbitrated until the block returns to IDLE.
- `tout` is 0 in every cycle except the one following a timeout revoke.

## Timing
- Grant latency: `req` sampled nonzero in IDLE at edge k gives `en`=1 and a valid `w` after edge k, i.e. 1 cycle.
- Release latency: `done`=1 sampled at edge k gives `en`=0 after edge k.
- One mandatory IDLE bubble sits between consecutive grants. The next grant appears after edge k+1, so minimum grant spacing is 2 cycles.
- With a timeout, `en` is high for exactly `max_hold` cycles.
- `w` and `en` change only on clock edges, except on async reset, so the decoder output is glitch-free relative to `clk`.
- Fairness: with all requesters continuously requesting, grants cycle through 0,1,…,`2**n-1`,0,…

## Test plan
- Reset: drive `rst_n`=0 mid-grant with `en`=1 and `w`=5 → `en`=0, `w`=0, `tout`=0 immediately, before any clock edge. After release, `req`=8'h01 → `w`=0 granted (`ptr`=0).
- Priority/advance: from reset, `req`=8'b0010_0100 → `w`=2, `en`=1 one cycle later. Pulse `done` → `en`=0, then `w`=5, `en`=1 after the bubble.
- Wrap: complete a grant to index 7, then `req`=8'b1000_0001 → next grant is `w`=0 (`ptr` wrapped 7→0), not 7.
- Timeout: `max_hold`=16, `req`=8'h08, never assert `done` → `en` high exactly 16 cycles. `tout`=1 for one cycle as `en` falls; `ptr`=4.
- Collision: `done`=1 on the same edge the timeout would fire → `en`=0, `tout`=0. `done`=1 while IDLE with `req`=0 → no state change.
- Full load: `req`=8'hFF held for 16 grants, each released after 1 cycle → `w` sequence 0..7,0..7, with `en` high every other cycle.

Source files
------------

// File: rtl/rr_index_arbiter.sv
// rr_index_arbiter
// Round-robin arbiter over 2**n requesters. The winner is presented as a
// binary index plus an enable. Both are registered so they can feed a binary
// decoder directly. A grant is held until the holder raises i_done or the hold
// timeout expires. The priority pointer then moves just past the winner so
// that every requester gets fair service.
//
// Parameters:
//   n        - index width; number of requesters is 2**n
//   max_hold - maximum grant length in cycles without i_done (0 = no timeout)
// Ports:
//   i_clk    - rising-edge clock
//   i_rst_n  - asynchronous active-low reset
//   i_req    - request vector, bit i belongs to requester i
//   i_done   - current grant holder releases the grant
//   o_w      - granted index (registered)
//   o_en     - grant valid (registered)
//   o_tout   - one-cycle pulse after a grant is revoked by timeout
module rr_index_arbiter #(
  parameter int n        = 3,
  parameter int max_hold = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [2**n-1:0] i_req,
  input  logic            i_done,
  output logic [n-1:0]    o_w,
  output logic            o_en,
  output logic            o_tout
);

  localparam int NREQ = 2**n;
  localparam int CW   = (max_hold > 0) ? $clog2(max_hold + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((max_hold > 0) ? (max_hold - 1) : 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        r_state;
  logic [n-1:0]  r_ptr;
  logic [CW-1:0] r_cnt;

  state_t        w_stateNext;
  logic [n-1:0]  w_wNext;
  logic          w_enNext;
  logic          w_toutNext;
  logic [n-1:0]  w_ptrNext;
  logic [CW-1:0] w_cntNext;

  logic          w_found;
  logic [n-1:0]  w_winner;
  logic [n-1:0]  w_idx;
  logic          w_timeout;

  // Scan starting at the pointer. The n-bit addition wraps modulo 2**n on its
  // own, so no explicit wrap logic is needed.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_idx    = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = r_ptr + n'(i);
      if (!w_found && i_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // The timeout fires on the edge that would end the max_hold-th grant cycle.
  assign w_timeout = (max_hold != 0) && (r_cnt == LAST_CNT);

  // Next-state logic. When i_done and the timeout fire together, i_done wins,
  // so no tout pulse is produced.
  always_comb begin
    w_stateNext = r_state;
    w_wNext     = o_w;
    w_enNext    = o_en;
    w_toutNext  = 1'b0;
    w_ptrNext   = r_ptr;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        w_enNext = 1'b0;
        if (w_found) begin
          w_wNext     = w_winner;
          w_enNext    = 1'b1;
          w_cntNext   = '0;
          w_stateNext = GRANT;
        end
      end
      GRANT: begin
        if (i_done || w_timeout) begin
          w_enNext    = 1'b0;
          w_ptrNext   = o_w + n'(1);
          w_toutNext  = !i_done;
          w_stateNext = IDLE;
        end else begin
          w_cntNext = r_cnt + CW'(1);
        end
      end
      default: begin
        w_enNext    = 1'b0;
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and output registers. Outputs drop immediately on reset, even
  // mid-grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      o_w     <= '0;
      o_en    <= 1'b0;
      o_tout  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_ptr   <= w_ptrNext;
      r_cnt   <= w_cntNext;
      o_w     <= w_wNext;
      o_en    <= w_enNext;
      o_tout  <= w_toutNext;
    end
  end

endmodule

// File: tb/tb_rr_index_arbiter.sv
// tb_rr_index_arbiter
// Directed testbench for rr_index_arbiter (n=3, max_hold=16). Each scenario
// task drives its own stimulus and compares outputs against hand-computed
// values. Inputs are driven, and outputs sampled, 1ns after the rising edge.
module tb_rr_index_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] w;
  logic       en;
  logic       tout;

  int checks = 0;
  int errors = 0;

  rr_index_arbiter #(.n(3), .max_hold(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_done  (done),
    .o_w     (w),
    .o_en    (en),
    .o_tout  (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    done  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    req = '0; done = 1'b0; rst_n = 1'b0;
    #2;
    checks++;
    if ({en, w, tout} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_init: got en=%0b w=%0d tout=%0b expected 0/0/0", en, w, tout);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
    req = 8'h20;
    tick();
    checks++;
    if (en !== 1'b1 || w !== 3'd5) begin
      errors++;
      $display("[TB] FAIL reset_pregrant: got en=%0b w=%0d expected en=1 w=5", en, w);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (en !== 1'b0 || w !== 3'd0 || tout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: got en=%0b w=%0d tout=%0b expected 0/0/0", en, w, tout);
    end
    req = 8'h01;
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++;
    if (en !== 1'b1 || w !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_ptr0: got en=%0b w=%0d expected en=1 w=0", en, w);
    end
    done = 1'b1; req = '0;
    tick();
    done = 1'b0;
  endtask

  task automatic test_priority();
    do_reset();
    req = 8'b0010_0100;
    tick();
    checks++;
    if (en !== 1'b1 || w !== 3'd2) begin
      errors++;
      $display("[TB] FAIL prio_first: got en=%0b w=%0d expected en=1 w=2", en, w);
    end
    done = 1'b1;
    tick();
    checks++;
    if (en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_release: got en=%0b expected 0", en);
    end
    done = 1'b0;
    tick();
    checks++;
    if (en !== 1'b1 || w !== 3'd5) begin
      errors++;
      $display("[TB] FAIL prio_advance: got en=%0b w=%0d expected en=1 w=5", en, w);
    end
    done = 1'b1; req = '0;
    tick();
    done = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 8'h80;
    tick();
    checks++;
    if (en !== 1'b1 || w !== 3'd7) begin
      errors++;
      $display("[TB] FAIL wrap_grant7: got en=%0b w=%0d expected en=1 w=7", en, w);
    end
    done = 1'b1; req = '0;
    tick();
    done = 1'b0; req = 8'b1000_0001;
    tick();
    checks++;
    if (en !== 1'b1 || w !== 3'd0) begin
      errors++;
      $display("[TB] FAIL wrap_ptr0: got en=%0b w=%0d expected en=1 w=0", en, w);
    end
    done = 1'b1; req = '0;
    tick();
    done = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h08;
    tick();
    checks++;
    if (en !== 1'b1 || w !== 3'd3 || tout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tout_grant: got en=%0b w=%0d tout=%0b expected 1/3/0", en, w, tout);
    end
    // Dropping the request must not end the grant.
    req = '0;
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++;
      if (en !== 1'b1 || w !== 3'd3 || tout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL tout_hold cycle %0d: got en=%0b w=%0d tout=%0b expected 1/3/0", i, en, w, tout);
      end
    end
    tick();
    checks++;
    if (en !== 1'b0 || tout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tout_fire: got en=%0b tout=%0b expected en=0 tout=1", en, tout);
    end
    req = 8'h18;
    tick();
    checks++;
    if (tout !== 1'b0 || en !== 1'b1 || w !== 3'd4) begin
      errors++;
      $display("[TB] FAIL tout_ptr4: got en=%0b w=%0d tout=%0b expected 1/4/0", en, w, tout);
    end
    done = 1'b1; req = '0;
    tick();
    done = 1'b0;
  endtask

  task automatic test_collision();
    do_reset();
    req = 8'h02;
    tick();
    req = '0;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (en !== 1'b1 || w !== 3'd1) begin
      errors++;
      $display("[TB] FAIL coll_prefire: got en=%0b w=%0d expected en=1 w=1", en, w);
    end
    done = 1'b1;
    tick();
    checks++;
    if (en !== 1'b0 || tout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL coll_done_wins: got en=%0b tout=%0b expected 0/0", en, tout);
    end
    done = 1'b0; req = 8'h06;
    tick();
    checks++;
    if (en !== 1'b1 || w !== 3'd2 || tout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL coll_ptr2: got en=%0b w=%0d tout=%0b expected 1/2/0", en, w, tout);
    end
    done = 1'b1; req = '0;
    tick();
    // i_done while idle with no requests: nothing may change.
    tick();
    checks++;
    if (en !== 1'b0 || w !== 3'd2 || tout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL coll_idle_done: got en=%0b w=%0d tout=%0b expected 0/2/0", en, w, tout);
    end
    done = 1'b0; req = 8'hFF;
    tick();
    checks++;
    if (en !== 1'b1 || w !== 3'd3) begin
      errors++;
      $display("[TB] FAIL coll_idle_ptr: got en=%0b w=%0d expected en=1 w=3", en, w);
    end
    done = 1'b1; req = '0;
    tick();
    done = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] expW;
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 16; g++) begin
      expW = 3'(g % 8);
      tick();
      checks++;
      if (en !== 1'b1 || w !== expW || tout !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_grant %0d: got en=%0b w=%0d tout=%0b expected 1/%0d/0", g, en, w, tout, expW);
      end
      done = 1'b1;
      tick();
      checks++;
      if (en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_bubble %0d: got en=%0b expected 0", g, en);
      end
      done = 1'b0;
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_wrap();
    test_timeout();
    test_collision();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
